bcd_counter: RTL and testbench
==============================

# bcd_counter

Multi-digit synchronous BCD up/down counter that generates the packed BCD digit stream consumed by the BCD-to-Gray converter stage. Each 4-bit digit feeds one converter instance: digit bit 3 drives converter input a1 (MSB), bit 0 drives a4 (LSB). Supports parallel load, count enable, direction select, cascade carry-out, and flags illegal load digits.

## Interface
- DIGITS, 2, number of cascaded BCD digits (1..8)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  parallel load strobe
- load_val  input  4*DIGITS  packed BCD load value; digit k at bits [4k+3:4k], digit 0 least significant
- count  output  4*DIGITS  packed BCD count, same packing as load_val; registered
- tc  output  1  terminal count / cascade carry, combinational
- load_err  output  1  registered flag: last load contained an illegal digit

## Operation
- Priority per rising clk edge: reset > load > count > hold.
- Reset (rst_n=0 at edge): count = 0, load_err = 0. Synchronous only; rst_n has no effect between edges.
- Load (load=1): each digit of load_val in 0..9 is loaded as-is; any digit 10..15 loads as 0. load_err = 1 if any digit was illegal, else 0. en/up ignored that cycle.
- load_err holds its value until the next load or reset; counting does not alter it.
- Count (load=0, en=1):
  - up=1: digit 0 increments; digit k increments only when all lower digits were 9; a digit at 9 that increments becomes 0. All-9s wraps to all-0s.
  - up=0: digit 0 decrements; digit k decrements only when all lower digits were 0; a digit at 0 that decrements becomes 9. All-0s wraps to all-9s.
- Hold (load=0, en=0): count unchanged.
- tc = en & ~load & (up ? every digit == 9 : every digit == 0). Asserted in the cycle before wrap, intended as en of a following cascaded counter.
- Every count digit is always in 0..9 (invariant after reset; load sanitizes illegal input).
- No arithmetic is performed beyond per-digit ±1 with ripple enable; no binary-to-BCD conversion.

## Timing
- count and load_err: change only on rising clk; 1-cycle latency from load/en to new value.
- tc: combinational from en, load, up, and registered count; no registered delay.
- Direction change (up toggled) takes effect at the next enabled edge; no extra cycle.
- load and en together: load wins, no count that cycle; tc = 0.
- Reset asserted mid-count or coincident with load: count = 0, load_err = 0 at that edge; first count/load after rst_n returns high happens at the next edge.
- Outputs before first reset edge are undefined; bench must apply reset ≥1 cycle.

## Test plan
- Reset: rst_n=0 one edge with count at 47 -> count=0x00, load_err=0, tc=0 (en=0).
- Up count with wrap (DIGITS=2): load 0x97, en=1 up=1 for 3 edges -> 0x98, 0x99 (tc=1 while 0x99 and en=1), 0x00; tc=0 thereafter.
- Down count with borrow: load 0x10, en=1 up=0 -> 0x09, then 0x08; load 0x00, up=0 -> tc=1, next edge 0x99.
- Illegal load: load_val=0x3C -> count=0x30, load_err=1; following 5 up counts -> count=0x35, load_err still 1; load 0x42 -> load_err=0.
- Priority: load=1 en=1 load_val=0x55 at count 0x99 up=1 -> count=0x55, tc=0 that cycle; en=0 for 4 edges -> count stays 0x55.
- Reset mid-operation: counting up from 0x20, drop rst_n on 3rd edge -> count=0x00 at that edge; release -> next enabled edge 0x01.

Source files
------------

// File: rtl/bcd_counter_if.sv
// Control, load and status signals of the BCD counter, grouped for the
// driving stage (master) and the counter itself (slave).
interface bcd_counter_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  load_err;

  modport master (
    output en, up, load, load_val,
    input  count, tc, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, load_err
  );
endinterface

// File: rtl/bcd_counter.sv
// Multi-digit synchronous BCD up/down counter with sanitizing parallel load,
// ripple digit enable and combinational terminal-count cascade output.
module bcd_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_counter_if.slave  bus
);

  logic [4*DIGITS-1:0] r_count;
  logic                r_load_err;

  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_load_clean;
  logic                w_load_bad;
  logic                w_all_nine;
  logic                w_all_zero;
  logic                w_ripple;

  // Each digit steps only while every lower digit sits at its wrap value.
  always_comb begin
    w_next     = r_count;
    w_ripple   = 1'b1;
    w_all_nine = 1'b1;
    w_all_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (w_ripple) begin
        if (bus.up)
          w_next[4*k +: 4] = (r_count[4*k +: 4] == 4'd9) ? 4'd0 : r_count[4*k +: 4] + 4'd1;
        else
          w_next[4*k +: 4] = (r_count[4*k +: 4] == 4'd0) ? 4'd9 : r_count[4*k +: 4] - 4'd1;
      end
      w_all_nine = w_all_nine & (r_count[4*k +: 4] == 4'd9);
      w_all_zero = w_all_zero & (r_count[4*k +: 4] == 4'd0);
      w_ripple   = bus.up ? w_all_nine : w_all_zero;
    end
  end

  always_comb begin
    w_load_clean = '0;
    w_load_bad   = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bus.load_val[4*k +: 4] > 4'd9)
        w_load_bad = 1'b1;
      else
        w_load_clean[4*k +: 4] = bus.load_val[4*k +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      r_count    <= w_load_clean;
      r_load_err <= w_load_bad;
    end else if (bus.en) begin
      r_count    <= w_next;
    end
  end

  assign bus.count    = r_count;
  assign bus.load_err = r_load_err;
  assign bus.tc       = bus.en & ~bus.load & (bus.up ? w_all_nine : w_all_zero);

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter (DIGITS=2): reset, wrap, borrow, illegal
// load sanitizing, load priority and reset during counting.
module tb_bcd_counter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bcd_counter_if #(.DIGITS(2)) bus ();

  bcd_counter #(.DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load     = 1'b1;
    bus.en       = 1'b0;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset;
    do_load(8'h47);
    n_checks++;
    if (bus.count !== 8'h47) begin
      n_fail++; $display("FAIL reset_preload: count=%h expected=%h", bus.count, 8'h47);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.count !== 8'h47) begin
      n_fail++; $display("FAIL reset_sync_only: count=%h expected=%h", bus.count, 8'h47);
    end
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.count !== 8'h00 || bus.load_err !== 1'b0 || bus.tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%h load_err=%b tc=%b expected count=00 load_err=0 tc=0",
               bus.count, bus.load_err, bus.tc);
    end
  endtask

  task automatic test_up_wrap;
    logic [7:0] exp_c [3];
    logic       exp_tc [3];
    exp_c[0] = 8'h98; exp_c[1] = 8'h99; exp_c[2] = 8'h00;
    exp_tc[0] = 1'b0; exp_tc[1] = 1'b1;  exp_tc[2] = 1'b0;
    do_load(8'h97);
    bus.en = 1'b1; bus.up = 1'b1;
    #1;
    n_checks++;
    if (bus.count !== 8'h97 || bus.tc !== 1'b0) begin
      n_fail++; $display("FAIL up_start: count=%h tc=%b expected count=97 tc=0", bus.count, bus.tc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.count !== exp_c[i] || bus.tc !== exp_tc[i]) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: count=%h tc=%b expected count=%h tc=%b",
                 i, bus.count, bus.tc, exp_c[i], exp_tc[i]);
      end
    end
    bus.en = 1'b0;
    tick();
    n_checks++;
    if (bus.count !== 8'h00 || bus.tc !== 1'b0) begin
      n_fail++; $display("FAIL up_hold: count=%h tc=%b expected count=00 tc=0", bus.count, bus.tc);
    end
  endtask

  task automatic test_down_borrow;
    do_load(8'h10);
    bus.en = 1'b1; bus.up = 1'b0;
    tick();
    n_checks++;
    if (bus.count !== 8'h09 || bus.tc !== 1'b0) begin
      n_fail++; $display("FAIL down_borrow: count=%h tc=%b expected count=09 tc=0", bus.count, bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h08) begin
      n_fail++; $display("FAIL down_step: count=%h expected=08", bus.count);
    end
    do_load(8'h00);
    bus.en = 1'b1; bus.up = 1'b0;
    #1;
    n_checks++;
    if (bus.tc !== 1'b1) begin
      n_fail++; $display("FAIL down_tc: tc=%b expected=1", bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h99 || bus.tc !== 1'b0) begin
      n_fail++; $display("FAIL down_wrap: count=%h tc=%b expected count=99 tc=0", bus.count, bus.tc);
    end
    bus.up = 1'b1;
    #1;
    n_checks++;
    if (bus.tc !== 1'b1) begin
      n_fail++; $display("FAIL dir_tc: tc=%b expected=1", bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h00) begin
      n_fail++; $display("FAIL dir_change: count=%h expected=00", bus.count);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_illegal_load;
    do_load(8'h3C);
    n_checks++;
    if (bus.count !== 8'h30 || bus.load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_load: count=%h load_err=%b expected count=30 load_err=1", bus.count, bus.load_err);
    end
    bus.en = 1'b1; bus.up = 1'b1;
    repeat (5) tick();
    bus.en = 1'b0;
    n_checks++;
    if (bus.count !== 8'h35 || bus.load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: count=%h load_err=%b expected count=35 load_err=1", bus.count, bus.load_err);
    end
    do_load(8'h42);
    n_checks++;
    if (bus.count !== 8'h42 || bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL legal_load: count=%h load_err=%b expected count=42 load_err=0", bus.count, bus.load_err);
    end
    do_load(8'hAF);
    n_checks++;
    if (bus.count !== 8'h00 || bus.load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL both_illegal: count=%h load_err=%b expected count=00 load_err=1", bus.count, bus.load_err);
    end
  endtask

  task automatic test_priority;
    do_load(8'h99);
    bus.load = 1'b1; bus.en = 1'b1; bus.up = 1'b1; bus.load_val = 8'h55;
    #1;
    n_checks++;
    if (bus.tc !== 1'b0) begin
      n_fail++; $display("FAIL prio_tc: tc=%b expected=0", bus.tc);
    end
    tick();
    n_checks++;
    if (bus.count !== 8'h55 || bus.tc !== 1'b0 || bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_load: count=%h tc=%b load_err=%b expected count=55 tc=0 load_err=0",
               bus.count, bus.tc, bus.load_err);
    end
    bus.load = 1'b0; bus.en = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (bus.count !== 8'h55) begin
      n_fail++; $display("FAIL prio_hold: count=%h expected=55", bus.count);
    end
  endtask

  task automatic test_reset_mid;
    do_load(8'h2A);
    bus.en = 1'b1; bus.up = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.count !== 8'h22 || bus.load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: count=%h load_err=%b expected count=22 load_err=1", bus.count, bus.load_err);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.count !== 8'h00 || bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: count=%h load_err=%b expected count=00 load_err=0", bus.count, bus.load_err);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.count !== 8'h01) begin
      n_fail++; $display("FAIL mid_release: count=%h expected=01", bus.count);
    end
    bus.en = 1'b0;
    rst_n = 1'b0; bus.load = 1'b1; bus.load_val = 8'h3C;
    tick();
    rst_n = 1'b1; bus.load = 1'b0;
    n_checks++;
    if (bus.count !== 8'h00 || bus.load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_over_load: count=%h load_err=%b expected count=00 load_err=0", bus.count, bus.load_err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_illegal_load();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
